// File: rtl/keyseq_rec.sv
// rtl/keyseq_rec.sv - PS/2 scan-code sequence recogniser with key bitmap and event FIFO
module keyseq_rec #(
    parameter int         FIFO_DEPTH      = 4,
    parameter int         SUPPRESS_REPEAT = 1,
    parameter int         TIMEOUT_CYC     = 50000,
    parameter logic [8:0] PAUSE_CODE      = 9'h1E1
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       din_new,
    input  logic [7:0] din,
    input  logic       ev_ready,
    output logic       ev_valid,
    output logic [8:0] ev_code,
    output logic       ev_brk,
    input  logic [8:0] query_code,
    output logic       query_pressed,
    input  logic       clr_ovf,
    output logic       ovf,
    output logic       err
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic [CW-1:0] FULL_CNT   = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WREL,
        S_WEXT,
        S_WEXTREL,
        S_PAUSE
    } state_t;

    // Sequence recogniser state
    state_t        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          err_q, err_d;

    // Candidate event, registered on the final byte of a sequence
    logic          cand_valid_q, cand_valid_d;
    logic [8:0]    cand_code_q, cand_code_d;
    logic          cand_brk_q, cand_brk_d;
    logic          cand_pause_q, cand_pause_d;

    // Pressed-key bitmap and event FIFO
    logic [511:0]  bitmap_q, bitmap_d;
    logic [9:0]    mem_q [FIFO_DEPTH];
    logic [9:0]    mem_d [FIFO_DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          query_q, query_d;

    logic is_nor, is_ext, is_rel, is_pau;
    logic push_req, do_push, do_pop, drop, full;

    assign is_nor = (din >= 8'h01) && (din <= 8'h83);
    assign is_ext = (din == 8'hE0);
    assign is_rel = (din == 8'hF0);
    assign is_pau = (din == 8'hE1);

    // Next-state logic: byte classification, prefix tracking and inter-byte timeout
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        timer_d      = timer_q;
        err_d        = 1'b0;
        cand_valid_d = 1'b0;
        cand_code_d  = cand_code_q;
        cand_brk_d   = cand_brk_q;
        cand_pause_d = cand_pause_q;

        case (state_q)
            S_IDLE: begin
                if (din_new) begin
                    if (is_nor) begin
                        cand_valid_d = 1'b1;
                        cand_code_d  = {1'b0, din};
                        cand_brk_d   = 1'b0;
                        cand_pause_d = 1'b0;
                    end else if (is_rel) begin
                        state_d = S_WREL;
                    end else if (is_ext) begin
                        state_d = S_WEXT;
                    end else if (is_pau) begin
                        state_d = S_PAUSE;
                        cnt_d   = 3'd0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_WREL: begin
                if (din_new) begin
                    state_d = S_IDLE;
                    if (is_nor) begin
                        cand_valid_d = 1'b1;
                        cand_code_d  = {1'b0, din};
                        cand_brk_d   = 1'b1;
                        cand_pause_d = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_WEXT: begin
                if (din_new) begin
                    if (is_nor) begin
                        state_d      = S_IDLE;
                        cand_valid_d = 1'b1;
                        cand_code_d  = {1'b1, din};
                        cand_brk_d   = 1'b0;
                        cand_pause_d = 1'b0;
                    end else if (is_rel) begin
                        state_d = S_WEXTREL;
                    end else begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
            S_WEXTREL: begin
                if (din_new) begin
                    state_d = S_IDLE;
                    if (is_nor) begin
                        cand_valid_d = 1'b1;
                        cand_code_d  = {1'b1, din};
                        cand_brk_d   = 1'b1;
                        cand_pause_d = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_PAUSE: begin
                // The Pause tail carries arbitrary bytes; only their number matters
                if (din_new) begin
                    if (cnt_q == 3'd6) begin
                        state_d      = S_IDLE;
                        cand_valid_d = 1'b1;
                        cand_code_d  = PAUSE_CODE;
                        cand_brk_d   = 1'b0;
                        cand_pause_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A stalled partial sequence is abandoned after TIMEOUT_CYC quiet cycles
        if (state_q != S_IDLE) begin
            if (din_new) begin
                timer_d = '0;
            end else if ((TIMEOUT_CYC != 0) && (timer_q == TIMER_LAST)) begin
                state_d = S_IDLE;
                timer_d = '0;
                err_d   = 1'b1;
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end else begin
            timer_d = '0;
        end
    end

    // Event stage: bitmap update, repeat suppression, FIFO push/pop and overflow flag
    always_comb begin
        full     = (count_q == FULL_CNT);
        do_pop   = ev_valid && ev_ready;
        push_req = cand_valid_q &&
                   !((SUPPRESS_REPEAT != 0) && !cand_pause_q && !cand_brk_q &&
                     bitmap_q[cand_code_q]);
        do_push  = push_req && (!full || do_pop);
        drop     = push_req && full && !do_pop;

        bitmap_d = bitmap_q;
        if (cand_valid_q && !cand_pause_q) begin
            bitmap_d[cand_code_q] = !cand_brk_q;
        end

        mem_d = mem_q;
        if (do_push) begin
            mem_d[wptr_q] = {cand_brk_q, cand_code_q};
        end
        wptr_d  = wptr_q + PW'(do_push);
        rptr_d  = rptr_q + PW'(do_pop);
        count_d = count_q + CW'(do_push) - CW'(do_pop);

        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end

        query_d = bitmap_q[query_code];
    end

    // State registers
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q      <= S_IDLE;
            cnt_q        <= 3'd0;
            timer_q      <= '0;
            err_q        <= 1'b0;
            cand_valid_q <= 1'b0;
            cand_code_q  <= 9'd0;
            cand_brk_q   <= 1'b0;
            cand_pause_q <= 1'b0;
            bitmap_q     <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 10'd0;
            end
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            ovf_q        <= 1'b0;
            query_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            timer_q      <= timer_d;
            err_q        <= err_d;
            cand_valid_q <= cand_valid_d;
            cand_code_q  <= cand_code_d;
            cand_brk_q   <= cand_brk_d;
            cand_pause_q <= cand_pause_d;
            bitmap_q     <= bitmap_d;
            mem_q        <= mem_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
            ovf_q        <= ovf_d;
            query_q      <= query_d;
        end
    end

    assign ev_valid      = (count_q != '0);
    assign ev_code       = ev_valid ? mem_q[rptr_q][8:0] : 9'd0;
    assign ev_brk        = ev_valid ? mem_q[rptr_q][9] : 1'b0;
    assign query_pressed = query_q;
    assign ovf           = ovf_q;
    assign err           = err_q;

endmodule

// File: tb/tb_keyseq_rec.sv
// tb/tb_keyseq_rec.sv - randomized self-checking bench for keyseq_rec against an event-level model
module tb_keyseq_rec;

    localparam int DEPTH = 4;
    localparam int TO    = 20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       din_new;
    logic [7:0] din;
    logic       ev_ready;
    logic [8:0] query_code;
    logic       clr_ovf;

    logic       ev_valid1, ev_brk1, query_pressed1, ovf1, err1;
    logic [8:0] ev_code1;
    logic       ev_valid0, ev_brk0, query_pressed0, ovf0, err0;
    logic [8:0] ev_code0;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: pressed keys, expected queue contents {brk, code}, sticky overflow
    bit       bm [512];
    bit [9:0] mq1 [$];
    bit [9:0] mq0 [$];
    bit       movf1, movf0;

    logic [7:0] pool [6] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h75, 8'h6B};
    logic [7:0] bad_idle [8] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'h84, 8'hE2};
    logic [7:0] bad_rel [6] = '{8'hAA, 8'hE0, 8'hE1, 8'hF0, 8'h00, 8'hFA};
    logic [7:0] bad_ext [5] = '{8'hAA, 8'hE0, 8'hE1, 8'h00, 8'hEE};
    logic [7:0] pause_seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    logic [7:0] five_keys [5] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
    logic [7:0] four_keys [4] = '{8'h1A, 8'h22, 8'h21, 8'h2A};

    always #5 clk = ~clk;

    keyseq_rec #(.FIFO_DEPTH(DEPTH), .SUPPRESS_REPEAT(1), .TIMEOUT_CYC(TO), .PAUSE_CODE(9'h1E1)) u_sup (
        .clk(clk), .resetN(rst_n), .din_new(din_new), .din(din), .ev_ready(ev_ready),
        .ev_valid(ev_valid1), .ev_code(ev_code1), .ev_brk(ev_brk1), .query_code(query_code),
        .query_pressed(query_pressed1), .clr_ovf(clr_ovf), .ovf(ovf1), .err(err1)
    );

    keyseq_rec #(.FIFO_DEPTH(DEPTH), .SUPPRESS_REPEAT(0), .TIMEOUT_CYC(TO), .PAUSE_CODE(9'h1E1)) u_rep (
        .clk(clk), .resetN(rst_n), .din_new(din_new), .din(din), .ev_ready(ev_ready),
        .ev_valid(ev_valid0), .ev_code(ev_code0), .ev_brk(ev_brk0), .query_code(query_code),
        .query_pressed(query_pressed0), .clr_ovf(clr_ovf), .ovf(ovf0), .err(err0)
    );

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        mq1.delete();
        mq0.delete();
        foreach (bm[i]) bm[i] = 1'b0;
        movf1 = 1'b0;
        movf0 = 1'b0;
    endtask

    // One recognised key event as seen by each consumer
    task automatic model_event(input bit [8:0] code, input bit brk, input bit pause);
        bit suppress;
        suppress = !brk && !pause && bm[code];
        if (!suppress) begin
            if (mq1.size() < DEPTH) mq1.push_back({brk, code});
            else movf1 = 1'b1;
        end
        if (mq0.size() < DEPTH) mq0.push_back({brk, code});
        else movf0 = 1'b1;
        if (!pause) bm[code] = !brk;
    endtask

    task automatic send(input logic [7:0] b, input bit exp_err);
        din = b;
        din_new = 1'b1;
        tick();
        chk("err_sup", 10'(err1), 10'(exp_err));
        chk("err_rep", 10'(err0), 10'(exp_err));
        din_new = 1'b0;
        tick();
        chk("err_clear", 10'(err1), 10'd0);
    endtask

    task automatic check_query(input logic [8:0] code);
        query_code = code;
        tick();
        chk("query_sup", 10'(query_pressed1), 10'(bm[code]));
        chk("query_rep", 10'(query_pressed0), 10'(bm[code]));
    endtask

    task automatic check_ovf();
        chk("ovf_sup", 10'(ovf1), 10'(movf1));
        chk("ovf_rep", 10'(ovf0), 10'(movf0));
    endtask

    task automatic clear_ovf();
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        movf1 = 1'b0;
        movf0 = 1'b0;
        check_ovf();
    endtask

    task automatic drain();
        while (mq1.size() > 0 || mq0.size() > 0) begin
            chk("valid_sup", 10'(ev_valid1), 10'(mq1.size() > 0));
            chk("valid_rep", 10'(ev_valid0), 10'(mq0.size() > 0));
            if (mq1.size() > 0) chk("head_sup", {ev_brk1, ev_code1}, mq1[0]);
            if (mq0.size() > 0) chk("head_rep", {ev_brk0, ev_code0}, mq0[0]);
            ev_ready = 1'b1;
            tick();
            ev_ready = 1'b0;
            if (mq1.size() > 0) void'(mq1.pop_front());
            if (mq0.size() > 0) void'(mq0.pop_front());
        end
        chk("empty_sup", 10'(ev_valid1), 10'd0);
        chk("empty_rep", 10'(ev_valid0), 10'd0);
    endtask

    task automatic check_reset_outputs();
        chk("rst_valid", {8'd0, ev_valid1, ev_valid0}, 10'd0);
        chk("rst_code", {1'b0, ev_code1}, 10'd0);
        chk("rst_brk", {8'd0, ev_brk1, ev_brk0}, 10'd0);
        chk("rst_query", {8'd0, query_pressed1, query_pressed0}, 10'd0);
        chk("rst_ovf", {8'd0, ovf1, ovf0}, 10'd0);
        chk("rst_err", {8'd0, err1, err0}, 10'd0);
    endtask

    // kind: 0/1 make, 2 break, 3 ext make, 4 ext break, 5 pause, 6 bad byte, 7 F0+bad, 8 E0+bad
    task automatic do_seq(input int kind, input logic [7:0] key);
        case (kind)
            0, 1: begin
                send(key, 1'b0);
                model_event({1'b0, key}, 1'b0, 1'b0);
            end
            2: begin
                send(8'hF0, 1'b0);
                send(key, 1'b0);
                model_event({1'b0, key}, 1'b1, 1'b0);
            end
            3: begin
                send(8'hE0, 1'b0);
                send(key, 1'b0);
                model_event({1'b1, key}, 1'b0, 1'b0);
            end
            4: begin
                send(8'hE0, 1'b0);
                send(8'hF0, 1'b0);
                send(key, 1'b0);
                model_event({1'b1, key}, 1'b1, 1'b0);
            end
            5: begin
                send(8'hE1, 1'b0);
                for (int i = 0; i < 7; i++) send(8'($urandom_range(0, 255)), 1'b0);
                model_event(9'h1E1, 1'b0, 1'b1);
            end
            6: send(bad_idle[$urandom_range(0, 7)], 1'b1);
            7: begin
                send(8'hF0, 1'b0);
                send(bad_rel[$urandom_range(0, 5)], 1'b1);
            end
            default: begin
                send(8'hE0, 1'b0);
                send(bad_ext[$urandom_range(0, 4)], 1'b1);
            end
        endcase
    endtask

    initial begin
        rst_n = 1'b0;
        din_new = 1'b0;
        din = 8'h00;
        ev_ready = 1'b0;
        query_code = 9'd0;
        clr_ovf = 1'b0;
        model_reset();
        tick();
        tick();
        check_reset_outputs();
        rst_n = 1'b1;
        tick();

        // Make latency: nothing after the sampling edge, event one edge later
        din = 8'h1C;
        din_new = 1'b1;
        tick();
        din_new = 1'b0;
        chk("lat_early", 10'(ev_valid1), 10'd0);
        tick();
        chk("lat_valid", 10'(ev_valid1), 10'd1);
        chk("lat_head", {ev_brk1, ev_code1}, 10'h01C);
        model_event(9'h01C, 1'b0, 1'b0);
        check_query(9'h01C);
        drain();
        do_seq(2, 8'h1C);
        check_query(9'h01C);
        drain();

        // Extended make and break
        do_seq(3, 8'h75);
        check_query(9'h175);
        do_seq(4, 8'h75);
        check_query(9'h175);
        drain();

        // Typematic repeats
        for (int i = 0; i < 3; i++) do_seq(0, 8'h1C);
        chk("rep_cnt_sup", 10'(mq1.size()), 10'd1);
        drain();
        do_seq(2, 8'h1C);
        drain();

        // Pause sequence leaves the bitmap alone
        for (int i = 0; i < 8; i++) send(pause_seq[i], 1'b0);
        model_event(9'h1E1, 1'b0, 1'b1);
        check_query(9'h014);
        check_query(9'h077);
        check_query(9'h1E1);
        drain();

        // Overflow: five makes into a four-entry queue
        for (int i = 0; i < 5; i++) do_seq(0, five_keys[i]);
        check_ovf();
        chk("ovf_set", 10'(ovf1), 10'd1);
        drain();
        check_ovf();
        clear_ovf();

        // Push and pop in the same cycle while full
        for (int i = 0; i < 4; i++) do_seq(0, four_keys[i]);
        chk("full_head", {ev_brk1, ev_code1}, mq1[0]);
        din = 8'h32;
        din_new = 1'b1;
        tick();
        din_new = 1'b0;
        ev_ready = 1'b1;
        tick();
        ev_ready = 1'b0;
        void'(mq1.pop_front());
        void'(mq0.pop_front());
        model_event(9'h032, 1'b0, 1'b0);
        check_ovf();
        drain();

        // Timeout after E0
        send(8'hE0, 1'b0);
        for (int k = 2; k < TO; k++) begin
            tick();
            chk("to_early", {8'd0, err1, err0}, 10'd0);
        end
        tick();
        chk("to_err", {8'd0, err1, err0}, 10'h3);
        tick();
        chk("to_clear", 10'(err1), 10'd0);
        chk("to_noev", {8'd0, ev_valid1, ev_valid0}, 10'd0);
        do_seq(0, 8'h3C);
        drain();

        // Release prefix followed by a bad byte
        send(8'hF0, 1'b0);
        send(8'hAA, 1'b1);
        chk("bad_noev", {8'd0, ev_valid1, ev_valid0}, 10'd0);
        do_seq(0, 8'h44);
        drain();

        // Reset in the middle of a release sequence
        send(8'hF0, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        tick();
        rst_n = 1'b1;
        model_reset();
        tick();
        do_seq(0, 8'h1C);
        check_query(9'h01C);
        drain();

        // Randomized batches of sequences
        for (int batch = 0; batch < 60; batch++) begin
            int n;
            n = $urandom_range(1, 6);
            for (int s = 0; s < n; s++) begin
                do_seq($urandom_range(0, 8), pool[$urandom_range(0, 5)]);
            end
            check_ovf();
            check_query({1'($urandom_range(0, 1)), pool[$urandom_range(0, 5)]});
            drain();
            clear_ovf();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
